// File: rtl/btn_event_conditioner.sv
// -----------------------------------------------------------------------------
// btn_event_conditioner
//
// Button front-end for the whack-a-mole core. Every raw button pin is brought
// into the clk domain through a two-flop synchroniser, then debounced. The
// block presents a clean level per button, single-cycle rise/fall pulses, and
// a small valid/ready FIFO of press events (button indices). Simultaneous
// presses are serialised lowest index first, one FIFO push per cycle.
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst           synchronous, active-high reset
//   btn_raw       asynchronous raw button inputs, 1 = pressed
//   btn_level     debounced button levels
//   btn_rise      one-cycle pulse when btn_level goes 0->1
//   btn_fall      one-cycle pulse when btn_level goes 1->0
//   evt_valid     press-event FIFO non-empty
//   evt_ready     consumer accepts the head entry when evt_valid && evt_ready
//   evt_idx       button index of the head entry, 0 when empty
//   evt_overflow  sticky: a press event was lost
//   clr_overflow  clears evt_overflow (a simultaneous new loss wins)
// -----------------------------------------------------------------------------
module btn_event_conditioner #(
    parameter  int NUM_BTN         = 8,
    parameter  int DEBOUNCE_CYCLES = 16,
    parameter  int FIFO_DEPTH      = 4,
    localparam int IDX_W           = $clog2(NUM_BTN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_rise,
    output logic [NUM_BTN-1:0] btn_fall,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [IDX_W-1:0]   evt_idx,
    output logic               evt_overflow,
    input  logic               clr_overflow
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

    // Synchroniser and debounce state
    logic [NUM_BTN-1:0]            sync1;
    logic [NUM_BTN-1:0]            sync2;
    logic [NUM_BTN-1:0][CNT_W-1:0] db_cnt;
    logic [NUM_BTN-1:0][CNT_W-1:0] db_cnt_d;
    logic [NUM_BTN-1:0]            level_d;
    logic [NUM_BTN-1:0]            rise_d;
    logic [NUM_BTN-1:0]            fall_d;

    // A channel only produces press events once it has been seen released
    // after reset; this keeps a button held through reset from generating a
    // press when its debounced level first comes up.
    logic [NUM_BTN-1:0] armed;
    logic [NUM_BTN-1:0] armed_d;
    logic [1:0]         settle;
    logic               settle_done;

    // Pending bits and arbiter
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] pending_d;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] grant;
    logic [NUM_BTN-1:0] push_mask;
    logic [NUM_BTN-1:0] lost;
    logic [IDX_W-1:0]   grant_idx;
    logic               any_pending;

    // Event FIFO
    logic [IDX_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] count;
    logic              push;
    logic              pop;

    // -------------------------------------------------------------------------
    // Debounce next-state: level only follows sync2 after DEBOUNCE_CYCLES
    // consecutive cycles of disagreement; any agreement restarts the count.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        level_d  = btn_level;
        rise_d   = '0;
        fall_d   = '0;
        db_cnt_d = db_cnt;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (sync2[i] == btn_level[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt[i] == CNT_MAX) begin
                level_d[i]  = sync2[i];
                rise_d[i]   = sync2[i];
                fall_d[i]   = ~sync2[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt[i] + 1'b1;
            end
        end
    end

    // sync2 first carries a real sample two edges after reset; only then can
    // "released" be trusted for arming.
    assign settle_done = (settle == 2'd2);
    assign armed_d     = armed | fall_d | (settle_done ? (~btn_level & ~sync2) : '0);

    // -------------------------------------------------------------------------
    // Arbiter: lowest-index pending bit wins the single push slot per cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_idx   = '0;
        any_pending = |pending;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pending[i]) grant_idx = IDX_W'(i);
        end
        grant = any_pending ? (NUM_BTN'(1) << grant_idx) : '0;
    end

    assign pop       = evt_valid && evt_ready;
    assign push      = any_pending && ((count < FIFO_FULL) || pop);
    assign push_mask = push ? grant : '0;

    // A press collides only if the earlier press on that channel is still
    // waiting after this cycle; being pushed this same cycle is not a loss.
    assign press     = rise_d & armed;
    assign lost      = press & pending & ~push_mask;
    assign pending_d = (pending & ~push_mask) | press;

    assign evt_valid = (count != '0);
    assign evt_idx   = evt_valid ? fifo_mem[rd_ptr] : '0;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from pre-edge values.
        if (rst) begin
            sync1        <= '0;
            sync2        <= '0;
            btn_level    <= '0;
            btn_rise     <= '0;
            btn_fall     <= '0;
            db_cnt       <= '0;
            armed        <= '0;
            settle       <= '0;
            pending      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            evt_overflow <= 1'b0;
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            btn_level <= level_d;
            btn_rise  <= rise_d;
            btn_fall  <= fall_d;
            db_cnt    <= db_cnt_d;
            armed     <= armed_d;
            pending   <= pending_d;

            if (!settle_done) settle <= settle + 2'd1;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (|lost)             evt_overflow <= 1'b1;
            else if (clr_overflow) evt_overflow <= 1'b0;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; an entry is only ever
    // read after it has been written, and evt_idx is forced to 0 when empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= grant_idx;
    end

endmodule

// File: tb/tb_btn_event_conditioner.sv
// -----------------------------------------------------------------------------
// Testbench for btn_event_conditioner (NUM_BTN=8, DEBOUNCE_CYCLES=4,
// FIFO_DEPTH=4). Inputs are driven 1 time unit after the rising edge; a
// negedge monitor pops the expected-index scoreboard on every handshake.
// -----------------------------------------------------------------------------
module tb_btn_event_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] btn_raw;
    logic [7:0] btn_level;
    logic [7:0] btn_rise;
    logic [7:0] btn_fall;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_idx;
    logic       evt_overflow;
    logic       clr_overflow;

    int n_checks = 0;
    int n_err    = 0;

    logic [2:0] exp_q[$];

    typedef struct {
        logic [7:0] raw;
        logic [7:0] rise;
        logic [7:0] fall;
    } vec_t;

    vec_t vecs [7];

    btn_event_conditioner #(
        .NUM_BTN        (8),
        .DEBOUNCE_CYCLES(4),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_rise    (btn_rise),
        .btn_fall    (btn_fall),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_idx     (evt_idx),
        .evt_overflow(evt_overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until a rise or fall pulse is visible, at most budget cycles.
    task automatic wait_change(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if ((btn_rise | btn_fall) != 8'h00) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Press button b with the consumer stalled or not, then release it.
    task automatic press_release(input int b);
        btn_raw = 8'(1) << b;
        repeat (7) tick();
        btn_raw = 8'h00;
        repeat (7) tick();
    endtask

    // Scoreboard monitor: a handshake seen at negedge completes on the next posedge.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL evt_pop: got idx %0d expected no event", evt_idx);
            end else begin
                check("evt_pop_idx", 32'(evt_idx), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        logic [7:0] acc;

        vecs[0] = '{raw: 8'h08, rise: 8'h08, fall: 8'h00};
        vecs[1] = '{raw: 8'h00, rise: 8'h00, fall: 8'h08};
        vecs[2] = '{raw: 8'h81, rise: 8'h81, fall: 8'h00};
        vecs[3] = '{raw: 8'h01, rise: 8'h00, fall: 8'h80};
        vecs[4] = '{raw: 8'h00, rise: 8'h00, fall: 8'h01};
        vecs[5] = '{raw: 8'h24, rise: 8'h24, fall: 8'h00};
        vecs[6] = '{raw: 8'h00, rise: 8'h00, fall: 8'h24};

        rst          = 1'b1;
        btn_raw      = 8'h00;
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_level",    32'(btn_level),    32'h0);
        check("rst_rise",     32'(btn_rise),     32'h0);
        check("rst_fall",     32'(btn_fall),     32'h0);
        check("rst_valid",    32'(evt_valid),    32'h0);
        check("rst_idx",      32'(evt_idx),      32'h0);
        check("rst_overflow", 32'(evt_overflow), 32'h0);
        rst = 1'b0;
        repeat (5) tick();

        // ---------------- 1. clean press, exact latency ----------------
        btn_raw = 8'h08;
        repeat (5) tick();
        check("t1_level_e4", 32'(btn_level), 32'h00);
        tick();
        check("t1_level_e5", 32'(btn_level), 32'h08);
        check("t1_rise_e5",  32'(btn_rise),  32'h08);
        check("t1_valid_e5", 32'(evt_valid), 32'h0);
        exp_q.push_back(3'd3);
        tick();
        check("t1_rise_e6",  32'(btn_rise),  32'h00);
        check("t1_valid_e6", 32'(evt_valid), 32'h1);
        check("t1_idx_e6",   32'(evt_idx),   32'h3);
        evt_ready = 1'b1;
        tick();
        check("t1_valid_e7", 32'(evt_valid), 32'h0);
        btn_raw = 8'h00;
        repeat (8) tick();

        // ---------------- 2. bounce ----------------
        acc = 8'h00;
        btn_raw = 8'h01; tick(); acc |= btn_rise;
        btn_raw = 8'h00; tick(); acc |= btn_rise;
        btn_raw = 8'h01; tick(); acc |= btn_rise;
        btn_raw = 8'h00; tick(); acc |= btn_rise;
        btn_raw = 8'h01;
        repeat (5) begin
            tick();
            acc |= btn_rise;
        end
        check("t2_no_early_rise", 32'(acc), 32'h00);
        tick();
        check("t2_rise",  32'(btn_rise),  32'h01);
        check("t2_level", 32'(btn_level), 32'h01);
        exp_q.push_back(3'd0);
        repeat (6) tick();
        check("t2_drained", 32'(evt_valid), 32'h0);
        btn_raw = 8'h00;
        repeat (8) tick();

        // ---------------- table-driven level/pulse vectors ----------------
        for (int v = 0; v < 7; v++) begin
            btn_raw = vecs[v].raw;
            wait_change(20, ok);
            check($sformatf("vec%0d_seen", v),  32'(ok),        32'h1);
            check($sformatf("vec%0d_rise", v),  32'(btn_rise),  32'(vecs[v].rise));
            check($sformatf("vec%0d_fall", v),  32'(btn_fall),  32'(vecs[v].fall));
            check($sformatf("vec%0d_level", v), 32'(btn_level), 32'(vecs[v].raw));
            for (int b = 0; b < 8; b++) begin
                if (vecs[v].rise[b]) exp_q.push_back(3'(b));
            end
            repeat (8) tick();
        end

        // ---------------- 3. simultaneous presses 6,1,4 ----------------
        btn_raw = 8'h52;
        wait_change(20, ok);
        check("t3_seen", 32'(ok),       32'h1);
        check("t3_rise", 32'(btn_rise), 32'h52);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd6);
        tick();
        check("t3_first_valid",  32'(evt_valid), 32'h1);
        check("t3_first_idx",    32'(evt_idx),   32'h1);
        tick();
        check("t3_second_idx",   32'(evt_idx),   32'h4);
        tick();
        check("t3_third_idx",    32'(evt_idx),   32'h6);
        tick();
        check("t3_empty",        32'(evt_valid), 32'h0);
        check("t3_overflow",     32'(evt_overflow), 32'h0);
        btn_raw = 8'h00;
        repeat (8) tick();

        // ---------------- 4/5. backpressure, overflow, clear ----------------
        evt_ready = 1'b0;
        for (int b = 0; b < 5; b++) begin
            press_release(b);
            exp_q.push_back(3'(b));
        end
        check("t4_full_valid", 32'(evt_valid),    32'h1);
        check("t4_head_idx",   32'(evt_idx),      32'h0);
        check("t4_no_ovf_yet", 32'(evt_overflow), 32'h0);
        clr_overflow = 1'b1;
        btn_raw      = 8'h10;
        wait_change(12, ok);
        check("t4_repress_seen", 32'(ok),           32'h1);
        check("t4_repress_rise", 32'(btn_rise),     32'h10);
        check("t5_set_wins",     32'(evt_overflow), 32'h1);
        tick();
        check("t5_clear",        32'(evt_overflow), 32'h0);
        clr_overflow = 1'b0;
        btn_raw      = 8'h00;
        evt_ready    = 1'b1;
        repeat (12) tick();
        check("t4_drained", 32'(evt_valid), 32'h0);
        check("t4_q_empty", 32'(exp_q.size()), 32'h0);

        // ---------------- 6. reset mid-operation ----------------
        evt_ready = 1'b0;
        press_release(1);
        press_release(3);
        check("t6_pre_valid", 32'(evt_valid), 32'h1);
        check("t6_pre_idx",   32'(evt_idx),   32'h1);
        btn_raw = 8'h04;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("t6_rst_level",    32'(btn_level),    32'h0);
        check("t6_rst_rise",     32'(btn_rise),     32'h0);
        check("t6_rst_valid",    32'(evt_valid),    32'h0);
        check("t6_rst_idx",      32'(evt_idx),      32'h0);
        check("t6_rst_overflow", 32'(evt_overflow), 32'h0);
        wait_change(12, ok);
        check("t6_held_seen",  32'(ok),        32'h1);
        check("t6_held_level", 32'(btn_level), 32'h04);
        evt_ready = 1'b1;
        repeat (6) tick();
        check("t6_no_event", 32'(evt_valid), 32'h0);
        btn_raw = 8'h00;
        repeat (7) tick();
        btn_raw = 8'h04;
        exp_q.push_back(3'd2);
        repeat (10) tick();
        check("t6_repress_drained", 32'(evt_valid), 32'h0);
        btn_raw = 8'h00;
        repeat (8) tick();

        check("final_q_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
